// File: rtl/avr_sysctl_pkg.sv
// Shared definitions for the AVR system controller: register offsets and STATUS layout.
package avr_sysctl_pkg;

    localparam logic [1:0] REG_BANK   = 2'd0;
    localparam logic [1:0] REG_MASK   = 2'd1;
    localparam logic [1:0] REG_PEND   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int STATUS_INSV_BIT = 7;
    localparam int STATUS_VECT_LSB = 0;
    localparam int STATUS_VECT_W   = 3;

    function automatic logic [7:0] status_byte(input logic in_service, input logic [2:0] vect);
        return {in_service, 4'b0000, vect};
    endfunction

endpackage

// File: rtl/avr_sysctl_irq_ctrl.sv
// Edge-triggered, maskable, fixed-priority interrupt controller (lowest index wins).
module irq_ctrl #(
    parameter int IRQ_N = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IRQ_N-1:0] irq_src,
    input  logic [IRQ_N-1:0] mask,
    input  logic [IRQ_N-1:0] pend_clr,
    input  logic             eoi,
    input  logic             intr_ack,
    output logic [IRQ_N-1:0] pend,
    output logic             in_service,
    output logic             intr,
    output logic [2:0]       vect
);

    logic [IRQ_N-1:0] prev;
    logic [IRQ_N-1:0] rise;
    logic [IRQ_N-1:0] ack_clr;
    logic             ack_fire;
    logic             cand_valid;
    logic [2:0]       cand;

    always_comb begin
        ack_fire   = intr_ack & intr;
        rise       = irq_src & ~prev;
        ack_clr    = '0;
        cand_valid = 1'b0;
        cand       = 3'd0;
        for (int i = 0; i < IRQ_N; i++) begin
            ack_clr[i] = ack_fire && (vect == 3'(i));
        end
        // Descending scan so the lowest pending, enabled source ends up selected.
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (pend[i] && mask[i]) begin
                cand_valid = 1'b1;
                cand       = 3'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        // Tracked during reset too, so a line already high at release is not an edge.
        prev <= irq_src;
        if (reset) begin
            pend       <= '0;
            in_service <= 1'b0;
            intr       <= 1'b0;
            vect       <= 3'd0;
        end else begin
            pend <= (pend & ~pend_clr & ~ack_clr) | rise;
            if (ack_fire) begin
                in_service <= 1'b1;
            end else if (eoi) begin
                in_service <= 1'b0;
            end
            if (!ack_fire && !in_service && cand_valid) begin
                intr <= 1'b1;
                vect <= cand;
            end else begin
                intr <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/avr_sysctl.sv
// AVR system controller: bank-window address mapping, register block and interrupt pins.
module avr_sysctl
    import avr_sysctl_pkg::*;
#(
    parameter int          ADDR_W    = 17,
    parameter logic [15:0] WIN_BASE  = 16'h8000,
    parameter int          WIN_BITS  = 14,
    parameter logic [15:0] CTRL_BASE = 16'h0040,
    parameter int          IRQ_N     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       cpu_address,
    input  logic [7:0]        cpu_data_o,
    input  logic              cpu_we,
    input  logic              cpu_read,
    output logic [7:0]        cpu_data_i,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_d,
    output logic              ram_we,
    input  logic [7:0]        ram_q,
    input  logic [IRQ_N-1:0]  irq_src,
    output logic              intr,
    output logic [2:0]        vect,
    input  logic              intr_ack
);

    localparam int BANK_W = ADDR_W - WIN_BITS;

    logic [BANK_W-1:0] bank;
    logic [IRQ_N-1:0]  mask;
    logic [IRQ_N-1:0]  pend;
    logic [IRQ_N-1:0]  pend_clr;
    logic              in_service;
    logic              eoi;
    logic              win_hit;
    logic              reg_hit;
    logic              reg_wr;
    logic [1:0]        reg_off;
    logic [7:0]        reg_rd_val;
    logic              sel_q;
    logic [7:0]        reg_q;

    always_comb begin
        win_hit     = cpu_address[15:WIN_BITS] == WIN_BASE[15:WIN_BITS];
        reg_hit     = cpu_address[15:2] == CTRL_BASE[15:2];
        reg_off     = cpu_address[1:0];
        reg_wr      = cpu_we & reg_hit & ~reset;
        ram_we      = cpu_we & ~reg_hit & ~reset;
        ram_d       = cpu_data_o;
        ram_address = win_hit ? {bank, cpu_address[WIN_BITS-1:0]} : ADDR_W'(cpu_address);
        pend_clr    = (reg_wr && reg_off == REG_PEND) ? cpu_data_o[IRQ_N-1:0] : '0;
        eoi         = reg_wr && reg_off == REG_STATUS;
        unique case (reg_off)
            REG_BANK: reg_rd_val = 8'(bank);
            REG_MASK: reg_rd_val = 8'(mask);
            REG_PEND: reg_rd_val = 8'(pend);
            default:  reg_rd_val = status_byte(in_service, vect);
        endcase
        cpu_data_i  = sel_q ? reg_q : ram_q;
    end

    // Registered read data lines register reads up with the RAM's one-cycle latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            bank  <= '0;
            mask  <= '0;
            sel_q <= 1'b0;
            reg_q <= 8'h00;
        end else begin
            sel_q <= reg_hit;
            if (cpu_read || reg_hit) begin
                reg_q <= reg_rd_val;
            end
            if (reg_wr && reg_off == REG_BANK) begin
                bank <= cpu_data_o[BANK_W-1:0];
            end
            if (reg_wr && reg_off == REG_MASK) begin
                mask <= cpu_data_o[IRQ_N-1:0];
            end
        end
    end

    irq_ctrl #(
        .IRQ_N(IRQ_N)
    ) u_irq_ctrl (
        .clock      (clock),
        .reset      (reset),
        .irq_src    (irq_src),
        .mask       (mask),
        .pend_clr   (pend_clr),
        .eoi        (eoi),
        .intr_ack   (intr_ack),
        .pend       (pend),
        .in_service (in_service),
        .intr       (intr),
        .vect       (vect)
    );

endmodule

// File: tb/tb_avr_sysctl.sv
// Self-checking bench for avr_sysctl: directed scenarios plus random traffic against a behavioural model.
module tb_avr_sysctl;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data_o;
    logic        cpu_we;
    logic        cpu_read;
    logic [7:0]  cpu_data_i;
    logic [16:0] ram_address;
    logic [7:0]  ram_d;
    logic        ram_we;
    logic [7:0]  ram_q;
    logic [7:0]  irq_src;
    logic        intr;
    logic [2:0]  vect;
    logic        intr_ack;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_bank = 0, m_mask = 0, m_pend = 0, m_insv = 0;
    int m_intr = 0, m_vect = 0, m_prev = 0, m_sel = 0, m_reg = 0;

    avr_sysctl dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_data_o  (cpu_data_o),
        .cpu_we      (cpu_we),
        .cpu_read    (cpu_read),
        .cpu_data_i  (cpu_data_i),
        .ram_address (ram_address),
        .ram_d       (ram_d),
        .ram_we      (ram_we),
        .ram_q       (ram_q),
        .irq_src     (irq_src),
        .intr        (intr),
        .vect        (vect),
        .intr_ack    (intr_ack)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int is_hit(input int a);
        return int'((a / 4) == (16'h0040 / 4));
    endfunction

    function automatic int exp_ram_addr(input int a);
        if (a >= 16'h8000 && a < 16'hC000) return m_bank * 16384 + (a % 16384);
        return a;
    endfunction

    function automatic int reg_value(input int off);
        case (off)
            0:       return m_bank;
            1:       return m_mask;
            2:       return m_pend;
            default: return m_insv * 128 + m_vect;
        endcase
    endfunction

    // One clock of the controller's rules, applied to the inputs present at the edge.
    task automatic model_clock();
        int a, off, d, irq, hit, rise, ack, clr, eoi, best;
        int nb, nm, np, ni, nt, nv, nr;
        a   = int'(cpu_address);
        off = a % 4;
        d   = int'(cpu_data_o);
        irq = int'(irq_src);
        if (reset) begin
            m_bank = 0; m_mask = 0; m_pend = 0; m_insv = 0;
            m_intr = 0; m_vect = 0; m_sel = 0; m_reg = 0;
            m_prev = irq;
            return;
        end
        hit  = is_hit(a);
        rise = irq & ~m_prev & 255;
        ack  = int'(intr_ack && m_intr != 0);
        clr  = 0;
        eoi  = 0;
        nb   = m_bank;
        nm   = m_mask;
        if (cpu_we && hit != 0) begin
            case (off)
                0:       nb = d % 8;
                1:       nm = d;
                2:       clr = d;
                default: eoi = 1;
            endcase
        end
        np = m_pend & ~clr;
        if (ack != 0) np = np & ~(1 << m_vect);
        np = np | rise;
        best = -1;
        for (int i = 0; i < 8; i++) begin
            if (best < 0 && (((m_pend & m_mask) >> i) & 1) != 0) best = i;
        end
        ni = (ack != 0) ? 1 : ((eoi != 0) ? 0 : m_insv);
        nt = 0;
        nv = m_vect;
        if (ack == 0 && m_insv == 0 && best >= 0) begin
            nt = 1;
            nv = best;
        end
        nr = reg_value(off);
        m_sel  = hit;
        m_reg  = nr;
        m_bank = nb; m_mask = nm; m_pend = np; m_insv = ni;
        m_intr = nt; m_vect = nv; m_prev = irq;
    endtask

    task automatic step();
        int exp_we;
        #1;
        exp_we = int'(cpu_we && is_hit(int'(cpu_address)) == 0 && !reset);
        check_val("ram_address", 32'(ram_address), 32'(exp_ram_addr(int'(cpu_address))));
        check_val("ram_we", 32'(ram_we), 32'(exp_we));
        check_val("ram_d", 32'(ram_d), 32'(cpu_data_o));
        @(posedge clock);
        model_clock();
        #1;
        check_val("intr", 32'(intr), 32'(m_intr));
        check_val("vect", 32'(vect), 32'(m_vect));
        check_val("cpu_data_i", 32'(cpu_data_i), (m_sel != 0) ? 32'(m_reg) : 32'(ram_q));
    endtask

    task automatic set_idle();
        cpu_we      = 1'b0;
        cpu_read    = 1'b0;
        intr_ack    = 1'b0;
        cpu_address = 16'h0000;
        cpu_data_o  = 8'h00;
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] d);
        cpu_address = 16'h0040 + 16'(off);
        cpu_data_o  = d;
        cpu_we      = 1'b1;
        step();
        set_idle();
    endtask

    task automatic rd(input logic [1:0] off, output logic [7:0] q);
        cpu_address = 16'h0040 + 16'(off);
        cpu_read    = 1'b1;
        step();
        q = cpu_data_i;
        set_idle();
    endtask

    task automatic ack_pulse();
        intr_ack = 1'b1;
        step();
        intr_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] q;
        set_idle();
        ram_q   = 8'h00;
        reset   = 1'b1;
        irq_src = 8'hFF;
        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();
        check_val("reset_intr", 32'(intr), 32'd0);
        check_val("reset_vect", 32'(vect), 32'd0);
        rd(2'd2, q); check_val("held_high_pend", 32'(q), 32'h00);
        rd(2'd0, q); check_val("reset_bank", 32'(q), 32'h00);
        rd(2'd1, q); check_val("reset_mask", 32'(q), 32'h00);
        rd(2'd3, q); check_val("reset_status", 32'(q), 32'h00);
        irq_src = 8'h00;
        step();

        wr(2'd0, 8'h02);
        cpu_address = 16'h8005; cpu_read = 1'b1;
        #1 check_val("bank_window", 32'(ram_address), 32'h08005);
        step(); set_idle();
        cpu_address = 16'h1234; cpu_read = 1'b1;
        #1 check_val("outside_window", 32'(ram_address), 32'h01234);
        step(); set_idle();

        cpu_address = 16'h0041; cpu_data_o = 8'hA5; cpu_we = 1'b1;
        #1 check_val("ram_we_reg_write", 32'(ram_we), 32'd0);
        step(); set_idle();
        rd(2'd1, q); check_val("mask_readback", 32'(q), 32'hA5);

        wr(2'd1, 8'hFF);
        irq_src = 8'h24; step();
        irq_src = 8'h00; step();
        check_val("prio_intr", 32'(intr), 32'd1);
        check_val("prio_vect", 32'(vect), 32'd2);
        ack_pulse();
        rd(2'd2, q); check_val("pend_after_ack", 32'(q), 32'h20);
        rd(2'd3, q); check_val("status_in_service", 32'(q), 32'h82);
        wr(2'd3, 8'h00);
        step();
        check_val("eoi_intr", 32'(intr), 32'd1);
        check_val("eoi_vect", 32'(vect), 32'd5);
        ack_pulse();
        wr(2'd3, 8'h00);
        step();
        check_val("drained_intr", 32'(intr), 32'd0);

        wr(2'd1, 8'h00);
        irq_src = 8'h08; step();
        irq_src = 8'h00; repeat (2) step();
        check_val("masked_intr", 32'(intr), 32'd0);
        rd(2'd2, q); check_val("masked_pend", 32'(q), 32'h08);
        wr(2'd1, 8'h08);
        step();
        check_val("unmask_intr", 32'(intr), 32'd1);
        check_val("unmask_vect", 32'(vect), 32'd3);
        ack_pulse();
        wr(2'd3, 8'h00);

        irq_src = 8'h02;
        wr(2'd2, 8'h02);
        irq_src = 8'h00;
        rd(2'd2, q); check_val("collision_pend", 32'(q), 32'h02);

        wr(2'd0, 8'h05);
        wr(2'd1, 8'hFF);
        step();
        check_val("pre_reset_vect", 32'(vect), 32'd1);
        ack_pulse();
        irq_src = 8'h10; step();
        irq_src = 8'h00; step();
        reset = 1'b1; step();
        check_val("mid_reset_intr", 32'(intr), 32'd0);
        reset = 1'b0;
        rd(2'd3, q); check_val("mid_reset_status", 32'(q), 32'h00);
        rd(2'd0, q); check_val("mid_reset_bank", 32'(q), 32'h00);
        rd(2'd2, q); check_val("mid_reset_pend", 32'(q), 32'h00);

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4)      cpu_address = 16'h0040 + 16'($urandom_range(0, 3));
            else if (r < 7) cpu_address = 16'h8000 + 16'($urandom_range(0, 16'h3FFF));
            else            cpu_address = 16'($urandom);
            cpu_we     = ($urandom_range(0, 3) == 0);
            cpu_read   = 1'($urandom);
            cpu_data_o = 8'($urandom);
            ram_q      = 8'($urandom);
            irq_src    = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            intr_ack   = ($urandom_range(0, 3) == 0);
            reset      = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        set_idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
